// File: rtl/mips_dump_pkg.sv
// ============================================================================
// Module   : mips_dump_pkg
// Purpose  : Shared types and constants for the MIPS post-run state dumper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_dump_pkg;

    localparam logic [7:0] HDR_MAGIC   = 8'hA5;
    localparam logic [7:0] REGION_REG  = 8'h01;
    localparam logic [7:0] REGION_DMEM = 8'h02;
    localparam int         IDX_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_REG = 3'd1,
        ST_REG     = 3'd2,
        ST_HDR_MEM = 3'd3,
        ST_MEM     = 3'd4,
        ST_CSUM    = 3'd5
    } dump_state_e;

    function automatic logic [31:0] build_header(input logic [7:0]  region,
                                                 input logic [15:0] count);
        return {HDR_MAGIC, region, count};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dump_out_stage.sv
// ============================================================================
// Module   : dump_out_stage
// Purpose  : Valid/ready output register with hold logic and running checksum.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dump_out_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              last_i,
    input  logic              csum_clr_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              fire_o,
    output logic [DATA_W-1:0] csum_next_o
);

    logic              valid_q, valid_d;
    logic              last_q,  last_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [DATA_W-1:0] csum_q,  csum_d;

    assign fire_o      = valid_q & ready_i;
    // Sum including the word being transferred now; used to build the checksum word.
    assign csum_next_o = csum_q + data_q;

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        csum_d  = csum_q;
        if (load_i) begin
            valid_d = 1'b1;
            last_d  = last_i;
            data_d  = word_i;
        end else if (fire_o) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
        if (csum_clr_i) begin
            csum_d = '0;
        end else if (fire_o) begin
            csum_d = csum_next_o;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            csum_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            csum_q  <= csum_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

`default_nettype wire

// File: rtl/mips_state_dumper.sv
// ============================================================================
// Module   : mips_state_dumper
// Purpose  : Streams register file and data memory out as framed 32-bit words.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mips_state_dumper #(
    parameter int REG_COUNT   = 32,
    parameter int DMEM_WORDS  = 256,
    parameter int DMEM_ADDR_W = 8,
    parameter int DATA_W      = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [4:0]             reg_rd_addr,
    input  logic [DATA_W-1:0]      reg_rd_data,
    output logic [DMEM_ADDR_W-1:0] dmem_rd_addr,
    input  logic [DATA_W-1:0]      dmem_rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_last
);

    import mips_dump_pkg::*;

    localparam logic [IDX_W-1:0] C_REG_CNT  = IDX_W'(REG_COUNT);
    localparam logic [IDX_W-1:0] C_DMEM_CNT = IDX_W'(DMEM_WORDS);

    dump_state_e       state_q, state_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;
    logic              done_q,  done_d;

    logic              ld;
    logic [DATA_W-1:0] ld_word;
    logic              ld_last;
    logic              csum_clr;
    logic              fire;
    logic [DATA_W-1:0] csum_next;

    // ptr_q is the index of the next word to fetch, so the read data is valid at the load edge.
    assign reg_rd_addr  = 5'(ptr_q);
    assign dmem_rd_addr = DMEM_ADDR_W'(ptr_q);
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        done_d   = 1'b0;
        ld       = 1'b0;
        ld_word  = '0;
        ld_last  = 1'b0;
        csum_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    csum_clr = 1'b1;
                    ld       = 1'b1;
                    ld_word  = build_header(REGION_REG, C_REG_CNT);
                    ptr_d    = '0;
                    state_d  = ST_HDR_REG;
                end
            end
            ST_HDR_REG, ST_REG: begin
                if (fire) begin
                    ld = 1'b1;
                    if (ptr_q == C_REG_CNT) begin
                        ld_word = build_header(REGION_DMEM, C_DMEM_CNT);
                        ptr_d   = '0;
                        state_d = ST_HDR_MEM;
                    end else begin
                        ld_word = reg_rd_data;
                        ptr_d   = ptr_q + 1'b1;
                        state_d = ST_REG;
                    end
                end
            end
            ST_HDR_MEM, ST_MEM: begin
                if (fire) begin
                    ld = 1'b1;
                    if (ptr_q == C_DMEM_CNT) begin
                        ld_word = csum_next;
                        ld_last = 1'b1;
                        ptr_d   = '0;
                        state_d = ST_CSUM;
                    end else begin
                        ld_word = dmem_rd_data;
                        ptr_d   = ptr_q + 1'b1;
                        state_d = ST_MEM;
                    end
                end
            end
            ST_CSUM: begin
                if (fire) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    dump_out_stage #(
        .DATA_W (DATA_W)
    ) u_out_stage (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_i      (ld),
        .word_i      (ld_word),
        .last_i      (ld_last),
        .csum_clr_i  (csum_clr),
        .ready_i     (out_ready),
        .valid_o     (out_valid),
        .data_o      (out_data),
        .last_o      (out_last),
        .fire_o      (fire),
        .csum_next_o (csum_next)
    );

endmodule

`default_nettype wire

// File: tb/tb_mips_state_dumper.sv
// ============================================================================
// Module   : tb_mips_state_dumper
// Purpose  : Self-checking bench for mips_state_dumper (4-word and empty dmem).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mips_state_dumper;

    localparam int NREG = 32;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  start_v, busy_v, done_v, valid_v, ready_v, last_v;
    logic [31:0] data_v  [2];
    logic [4:0]  raddr_v [2];
    logic [31:0] rdata_v [2];
    logic [7:0]  daddr_a;
    logic [0:0]  daddr_b;
    logic [31:0] ddata_a, ddata_b;

    logic [31:0] reg_mem [32];
    logic [31:0] dmem    [256];

    always #5 clock = ~clock;

    // Read data is scrambled whenever ready is low: the dumper must never capture it then.
    assign rdata_v[0] = reg_mem[raddr_v[0]] ^ {32{~ready_v[0]}};
    assign rdata_v[1] = reg_mem[raddr_v[1]] ^ {32{~ready_v[1]}};
    assign ddata_a    = dmem[daddr_a] ^ {32{~ready_v[0]}};
    assign ddata_b    = dmem[{7'd0, daddr_b}] ^ {32{~ready_v[1]}};

    mips_state_dumper #(.REG_COUNT(NREG), .DMEM_WORDS(4), .DMEM_ADDR_W(8), .DATA_W(32)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .reg_rd_addr(raddr_v[0]), .reg_rd_data(rdata_v[0]),
        .dmem_rd_addr(daddr_a), .dmem_rd_data(ddata_a),
        .out_valid(valid_v[0]), .out_ready(ready_v[0]), .out_data(data_v[0]), .out_last(last_v[0])
    );

    mips_state_dumper #(.REG_COUNT(NREG), .DMEM_WORDS(0), .DMEM_ADDR_W(1), .DATA_W(32)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .reg_rd_addr(raddr_v[1]), .reg_rd_data(rdata_v[1]),
        .dmem_rd_addr(daddr_b), .dmem_rd_data(ddata_b),
        .out_valid(valid_v[1]), .out_ready(ready_v[1]), .out_data(data_v[1]), .out_last(last_v[1])
    );

    typedef struct {
        int          sel;
        int          pct;
        int          busy_at;
        bit          rnd;
        logic [31:0] csum;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fill_fixed();
        for (int i = 0; i < 32; i++) reg_mem[i] = 32'(i);
        for (int j = 0; j < 256; j++) dmem[j] = 32'h100 + 32'(j);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 32; i++) reg_mem[i] = $urandom;
        for (int j = 0; j < 256; j++) dmem[j] = $urandom;
    endtask

    // Expected stream straight from the framing rules: header, data, header, data, sum.
    task automatic build_model(input int sel);
        int          nd;
        logic [31:0] s;
        nd = (sel == 0) ? 4 : 0;
        exp_q.delete();
        exp_q.push_back({8'hA5, 8'h01, 16'(NREG)});
        for (int i = 0; i < NREG; i++) exp_q.push_back(reg_mem[i]);
        exp_q.push_back({8'hA5, 8'h02, 16'(nd)});
        for (int j = 0; j < nd; j++) exp_q.push_back(dmem[j]);
        s = '0;
        foreach (exp_q[k]) s = s + exp_q[k];
        exp_q.push_back(s);
    endtask

    task automatic run_dump(input int sel, input int pct, input int busy_at, input bit chain,
                            output logic [31:0] csum_act);
        int          n      = 0;
        int          cyc    = 0;
        int          dones  = 0;
        bit          held   = 0;
        bit          fin    = 0;
        bit          pulsed = 0;
        logic [31:0] pd     = '0;
        logic        pl     = 1'b0;
        csum_act = '0;
        build_model(sel);
        start_v[sel] = 1'b1;
        ready_v[sel] = 1'b1;
        @(posedge clock); #1;
        start_v[sel] = 1'b0;
        chk("hdr_valid", 32'(valid_v[sel]), 32'd1);
        chk("hdr_busy",  32'(busy_v[sel]),  32'd1);
        chk("hdr_word",  data_v[sel], exp_q[0]);
        while (!fin && cyc < 2000) begin
            chk("valid_hi", 32'(valid_v[sel]), 32'd1);
            if (held) begin
                chk("hold_data", data_v[sel], pd);
                chk("hold_last", 32'(last_v[sel]), 32'(pl));
            end
            ready_v[sel] = (int'($urandom_range(99)) < pct);
            if (busy_at >= 0 && n == busy_at && !pulsed) begin
                start_v[sel] = 1'b1;
                pulsed       = 1;
            end else begin
                start_v[sel] = 1'b0;
            end
            dones += int'(done_v[sel]);
            if (valid_v[sel] && ready_v[sel]) begin
                chk("word", data_v[sel], exp_q[n]);
                chk("last", 32'(last_v[sel]), 32'(n == exp_q.size() - 1));
                if (n == exp_q.size() - 1) begin
                    csum_act = data_v[sel];
                    fin      = 1;
                end
                n++;
                held = 0;
            end else begin
                held = valid_v[sel];
            end
            pd = data_v[sel];
            pl = last_v[sel];
            @(posedge clock); #1;
            cyc++;
        end
        start_v[sel] = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d words expected %0d", n, exp_q.size());
        end
        chk("early_done", 32'(dones), 32'd0);
        chk("done_pulse", 32'(done_v[sel]),  32'd1);
        chk("busy_drop",  32'(busy_v[sel]),  32'd0);
        chk("valid_drop", 32'(valid_v[sel]), 32'd0);
        if (chain) begin
            start_v[sel] = 1'b1;
        end else begin
            @(posedge clock); #1;
            chk("done_once", 32'(done_v[sel]), 32'd0);
            chk("idle_busy", 32'(busy_v[sel]), 32'd0);
        end
    endtask

    initial begin
        vec_t        tbl [6];
        logic [31:0] cs;
        logic [31:0] cs2;

        tbl[0] = '{sel: 0, pct: 100, busy_at: -1, rnd: 0, csum: 32'h4A03061A};
        tbl[1] = '{sel: 0, pct: 50,  busy_at: -1, rnd: 0, csum: 32'h4A03061A};
        tbl[2] = '{sel: 0, pct: 100, busy_at: 10, rnd: 0, csum: 32'h4A03061A};
        tbl[3] = '{sel: 1, pct: 100, busy_at: -1, rnd: 0, csum: 32'h4A030210};
        tbl[4] = '{sel: 1, pct: 60,  busy_at: 5,  rnd: 0, csum: 32'h4A030210};
        tbl[5] = '{sel: 0, pct: 70,  busy_at: 20, rnd: 1, csum: 32'h0};

        reset_n = 1'b0;
        start_v = '0;
        ready_v = '0;
        fill_fixed();
        repeat (3) @(posedge clock);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_valid", 32'(valid_v[s]), 32'd0);
            chk("rst_busy",  32'(busy_v[s]),  32'd0);
            chk("rst_done",  32'(done_v[s]),  32'd0);
            chk("rst_last",  32'(last_v[s]),  32'd0);
            chk("rst_data",  data_v[s],       32'd0);
            chk("rst_raddr", 32'(raddr_v[s]), 32'd0);
        end
        chk("rst_daddr", 32'(daddr_a), 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int r = 0; r < 6; r++) begin
            if (tbl[r].rnd) fill_rand();
            else            fill_fixed();
            run_dump(tbl[r].sel, tbl[r].pct, tbl[r].busy_at, 0, cs);
            if (!tbl[r].rnd) chk("csum", cs, tbl[r].csum);
            repeat (2) @(posedge clock);
            #1;
        end

        // Asynchronous reset while streaming data memory.
        fill_fixed();
        start_v[0] = 1'b1;
        ready_v[0] = 1'b1;
        @(posedge clock); #1;
        start_v[0] = 1'b0;
        repeat (35) begin
            @(posedge clock); #1;
        end
        chk("pre_rst_busy", 32'(busy_v[0]), 32'd1);
        chk("pre_rst_word", data_v[0], 32'h101);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_v[0]), 32'd0);
        chk("arst_busy",  32'(busy_v[0]),  32'd0);
        chk("arst_done",  32'(done_v[0]),  32'd0);
        chk("arst_data",  data_v[0],       32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_dump(0, 100, -1, 0, cs);
        chk("post_rst_csum", cs, 32'h4A03061A);

        // Back-to-back: second start rides on the done cycle.
        run_dump(0, 100, -1, 1, cs);
        chk("b2b_csum1", cs, 32'h4A03061A);
        run_dump(0, 80, -1, 0, cs2);
        chk("b2b_csum2", cs2, 32'h4A03061A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_state_dumper.md
Name: mips_state_dumper

Overview:
Post-run state read-out engine for the single-cycle MIPS core. It walks the register file and data memory through their combinational read ports and streams every word out on a 32-bit valid/ready interface, framed by region headers and a trailing checksum. It is the synthesizable counterpart to the bench file dump of registers and data memory, and lets the same state be captured on silicon or FPGA after the program halts.

Parameters:
REG_COUNT, 32, number of register-file entries dumped, must be at most 65535
DMEM_WORDS, 256, number of data-memory words dumped, must be at most 65535
DMEM_ADDR_W, 8, data-memory word-address width, so that 2**DMEM_ADDR_W >= DMEM_WORDS
DATA_W, 32, word width, fixed at 32

Ports:
clock  in  1  single clock; all state changes on the rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a dump; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until the checksum word is accepted
done  out  1  one-cycle pulse in the cycle after the checksum word is accepted
reg_rd_addr  out  5  register-file read address; the read is combinational
reg_rd_data  in  32  register-file read data
dmem_rd_addr  out  DMEM_ADDR_W  data-memory word read address; the read is combinational
dmem_rd_data  in  32  data-memory read data
out_valid  out  1  stream word valid
out_ready  in  1  downstream ready
out_data  out  32  stream word
out_last  out  1  high only on the checksum word

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state goes to IDLE.
  - busy, done, out_valid and out_last are 0.
  - out_data, the index counters and the checksum are all 0.
  - The read addresses are 0.
- States and transitions: IDLE -> HDR_REG -> REG -> HDR_MEM -> MEM -> CSUM -> IDLE.
  - With DMEM_WORDS=0, HDR_MEM goes directly to CSUM.
  - With REG_COUNT=0, HDR_REG goes directly to HDR_MEM.
- Header word format: bits [31:24]=0xA5, bits [23:16]=region id, bits [15:0]=word count.
  - Register-region id is 0x01; data-memory-region id is 0x02.
- Stream order: register header, then reg[0..REG_COUNT-1], then data-memory header, then dmem[0..DMEM_WORDS-1], then the checksum.
  - Total words = REG_COUNT+DMEM_WORDS+3.
- Latency:
  - start=1 in IDLE at edge N gives out_valid=1 with the register header after edge N.
  - busy also rises after edge N.
- Output is a registered slice:
  - A word is transferred on an edge where out_valid&out_ready is 1.
  - On that same edge the next word is loaded. Read addresses are driven from the next-word index before the edge, so reg_rd_data or dmem_rd_data is captured directly.
  - With out_ready held at 1, the stream sustains one word per cycle with no bubbles.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and the internal state hold. Later changes on the read-data inputs are ignored.
- Checksum: a 32-bit sum modulo 2**32 of every transferred word before the checksum word, headers included. It is cleared when start is accepted.
- Completion:
  - After the checksum word transfers, out_valid and busy drop and the state returns to IDLE.
  - done is 1 for exactly one cycle, the cycle after that edge.
- start while busy is ignored and has no effect on the stream.
- start coincident with done is accepted (back-to-back dumps).
- Reset asserted mid-dump aborts immediately to the reset values. No partial checksum and no done pulse is produced.
- Register 0 is read through the port like any other register; the dumper applies no special-casing.
- Address counters count from 0 to count-1 and never wrap within a dump.

Decomposition:
- Shared package mips_dump_pkg contains:
  - the state enum;
  - HDR_MAGIC=8'hA5;
  - REGION_REG=8'h01 and REGION_DMEM=8'h02;
  - a header-build function taking (region, count).
- One natural sub-module, dump_out_stage: the valid/ready output register with its hold logic and checksum accumulator.
- The FSM and address counters stay in the top level.

Test Plan:
- Full dump, no backpressure. Setup: DMEM_WORDS=4, reg[i]=i, dmem[j]=0x100+j, out_ready=1, pulse start.
  - Required: 39 consecutive words starting with 0xA5010020.
  - Then 0..31, then 0xA5020004, then 0x100..0x103.
  - Then checksum 0x4A03061A with out_last=1, followed by a one-cycle done pulse.
- Random backpressure: same memory contents, out_ready random at 50%.
  - Required: an identical 39-word sequence.
  - out_data is stable whenever valid=1 and ready=0.
  - The checksum is unchanged.
- Start while busy: pulse start at word 10 of a dump.
  - Required: the stream is unaltered and exactly one done pulse occurs.
- Reset mid-dump: assert reset_n=0 asynchronously while the dump is in MEM.
  - Required: out_valid, busy and done are 0 immediately, before any clock edge.
  - A new start then yields a full correct dump beginning with 0xA5010020.
- Empty data-memory region: DMEM_WORDS=0.
  - Required: header 0xA5020000 directly followed by the checksum word; total words = REG_COUNT+3.
- Back-to-back: start asserted in the done cycle.
  - Required: the second dump's register header appears in the next cycle with the checksum restarted from 0.
